// File: rtl/adder_tree_feeder.sv
// Stream front end for the adder tree: gathers words into frames, issues them to the
// tree, tracks its fixed latency and returns the sums on a valid/ready stream.
module adder_tree_feeder #(
  parameter int ADDER_WIDTH  = 14,
  parameter int LEVELS       = 3,
  parameter int TREE_LATENCY = 2,
  parameter int RESULT_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ADDER_WIDTH-1:0]                in_data,
  input  logic                                  in_last,
  output logic [(2**LEVELS)*ADDER_WIDTH-1:0]    op_bus,
  output logic                                  op_strobe,
  input  logic [ADDER_WIDTH:0]                  tree_sum,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ADDER_WIDTH:0]                  out_sum,
  output logic [LEVELS:0]                       out_count
);

  localparam int N      = 2**LEVELS;
  localparam int SUM_W  = ADDER_WIDTH + 1;
  localparam int CNT_W  = LEVELS + 1;
  localparam int BUS_W  = N * ADDER_WIDTH;
  localparam int PTR_W  = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int OCC_W  = $clog2(RESULT_DEPTH + TREE_LATENCY + 1) + 1;

  logic [ADDER_WIDTH-1:0] lanes_r [N];
  logic [LEVELS-1:0]      wr_idx_r;
  logic                   frame_full_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [BUS_W-1:0]       lanes_flat_s;
  logic [BUS_W-1:0]       op_hold_r;

  logic [TREE_LATENCY-1:0] strobe_pipe_r;
  logic [CNT_W-1:0]        count_pipe_r [TREE_LATENCY];

  logic [SUM_W-1:0]  fifo_sum_r [RESULT_DEPTH];
  logic [CNT_W-1:0]  fifo_cnt_r [RESULT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [OCC_W-1:0]  fifo_count_r;
  logic [OCC_W-1:0]  inflight_s;
  logic [OCC_W-1:0]  occupancy_s;

  logic accept_s;
  logic last_word_s;
  logic issue_s;
  logic push_s;
  logic pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(RESULT_DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  // Handshake and issue decisions; a frame issues only if its result has a FIFO slot reserved.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < TREE_LATENCY; i++) begin
      inflight_s = inflight_s + OCC_W'(strobe_pipe_r[i]);
    end
    occupancy_s = fifo_count_r + inflight_s;
    in_ready    = !frame_full_r;
    accept_s    = in_valid && !frame_full_r;
    last_word_s = in_last || (wr_idx_r == LEVELS'(N - 1));
    issue_s     = frame_full_r && (occupancy_s < OCC_W'(RESULT_DEPTH));
    push_s      = strobe_pipe_r[TREE_LATENCY-1];
    out_valid   = (fifo_count_r != '0);
    pop_s       = out_valid && out_ready;
  end

  // Flatten the lane registers into the tree-side bus layout.
  always_comb begin
    lanes_flat_s = '0;
    for (int k = 0; k < N; k++) begin
      lanes_flat_s[k*ADDER_WIDTH +: ADDER_WIDTH] = lanes_r[k];
    end
  end

  // The frame appears on the bus in its issue cycle and is then held until the next issue.
  always_comb begin
    op_strobe = issue_s;
    if (issue_s) begin
      op_bus = lanes_flat_s;
    end else begin
      op_bus = op_hold_r;
    end
  end

  // Frame gathering: lane writes, write index, completion flag and frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        lanes_r[k] <= '0;
      end
      wr_idx_r     <= '0;
      frame_full_r <= 1'b0;
      cnt_r        <= '0;
    end else if (issue_s) begin
      for (int k = 0; k < N; k++) begin
        lanes_r[k] <= '0;
      end
      wr_idx_r     <= '0;
      frame_full_r <= 1'b0;
    end else if (accept_s) begin
      lanes_r[wr_idx_r] <= in_data;
      if (last_word_s) begin
        frame_full_r <= 1'b1;
        cnt_r        <= {1'b0, wr_idx_r} + CNT_W'(1);
      end else begin
        wr_idx_r <= wr_idx_r + LEVELS'(1);
      end
    end
  end

  // Holding register for the bus between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_hold_r <= '0;
    end else if (issue_s) begin
      op_hold_r <= lanes_flat_s;
    end
  end

  // Latency tracker: marks which cycle the tree output belongs to an issued frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_pipe_r <= '0;
      for (int i = 0; i < TREE_LATENCY; i++) begin
        count_pipe_r[i] <= '0;
      end
    end else begin
      strobe_pipe_r[0] <= issue_s;
      count_pipe_r[0]  <= cnt_r;
      for (int i = 1; i < TREE_LATENCY; i++) begin
        strobe_pipe_r[i] <= strobe_pipe_r[i-1];
        count_pipe_r[i]  <= count_pipe_r[i-1];
      end
    end
  end

  // Result FIFO storage; the credit scheme guarantees a push always has room.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RESULT_DEPTH; i++) begin
        fifo_sum_r[i] <= '0;
        fifo_cnt_r[i] <= '0;
      end
      wr_ptr_r <= '0;
    end else if (push_s) begin
      fifo_sum_r[wr_ptr_r] <= tree_sum;
      fifo_cnt_r[wr_ptr_r] <= count_pipe_r[TREE_LATENCY-1];
      wr_ptr_r             <= next_ptr(wr_ptr_r);
    end
  end

  // Read pointer and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
    end else begin
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + OCC_W'(1);
        2'b01:   fifo_count_r <= fifo_count_r - OCC_W'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // FIFO head drives the result stream.
  always_comb begin
    out_sum   = fifo_sum_r[rd_ptr_r];
    out_count = fifo_cnt_r[rd_ptr_r];
  end

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Scoreboard bench for adder_tree_feeder with a behavioural 2-cycle adder tree model.
module tb_adder_tree_feeder;

  localparam int AW = 14;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [AW-1:0]   in_data = '0;
  logic            in_last = 1'b0;
  logic [N*AW-1:0] op_bus;
  logic            op_strobe;
  logic [AW:0]     tree_sum = '0;
  logic [AW:0]     tree_s1 = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [AW:0]     out_sum;
  logic [3:0]      out_count;

  adder_tree_feeder #(.ADDER_WIDTH(14), .LEVELS(3), .TREE_LATENCY(2), .RESULT_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .op_bus(op_bus), .op_strobe(op_strobe), .tree_sum(tree_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  logic [AW:0]     exp_sum_q [$];
  logic [3:0]      exp_cnt_q [$];
  logic [N*AW-1:0] exp_lane_q [$];
  logic [N*AW-1:0] held_bus = '0;
  logic [AW-1:0]   cur_lanes [N];
  logic [AW:0]     cur_acc = '0;
  int              cur_n = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW:0] lane_sum(input logic [N*AW-1:0] bus);
    logic [AW:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + {1'b0, bus[k*AW +: AW]};
    return s;
  endfunction

  // Adder tree: samples the bus every cycle, sum valid two cycles later, carries dropped.
  always @(posedge clk) begin
    tree_s1  <= lane_sum(op_bus);
    tree_sum <= tree_s1;
  end

  // Monitor: checks issued lanes, bus stability and every result handshake.
  always @(negedge clk) begin
    logic [N*AW-1:0] el;
    logic [AW:0]     es;
    logic [3:0]      ec;
    if (rst) begin
      held_bus = '0;
    end else begin
      if (op_strobe) begin
        strobe_cnt++;
        if (exp_lane_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: got op_bus %0h expected no issue", op_bus);
        end else begin
          el = exp_lane_q.pop_front();
          chk("op_bus_lanes", op_bus, el);
        end
        held_bus = op_bus;
      end else begin
        chk("op_bus_stable", op_bus, held_bus);
      end
      if (out_valid && out_ready) begin
        if (exp_sum_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got sum %0h count %0d expected none", out_sum, out_count);
        end else begin
          es = exp_sum_q.pop_front();
          ec = exp_cnt_q.pop_front();
          chk("out_sum", out_sum, es);
          chk("out_count", out_count, ec);
        end
      end
    end
  end

  task automatic clear_model();
    for (int k = 0; k < N; k++) cur_lanes[k] = '0;
    cur_acc = '0;
    cur_n = 0;
  endtask

  task automatic send(input logic [AW-1:0] d, input logic l);
    logic [N*AW-1:0] packed_lanes;
    int w = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && w < 300) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    cur_lanes[cur_n] = d;
    cur_acc = cur_acc + {1'b0, d};
    cur_n++;
    if (l || cur_n == N) begin
      for (int k = 0; k < N; k++) packed_lanes[k*AW +: AW] = cur_lanes[k];
      exp_lane_q.push_back(packed_lanes);
      exp_sum_q.push_back(cur_acc);
      exp_cnt_q.push_back(4'(cur_n));
      clear_model();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_sum_q.delete(); exp_cnt_q.delete(); exp_lane_q.delete();
    clear_model();
  endtask

  task automatic drain();
    int w = 0;
    while (exp_sum_q.size() != 0 && w < 200) begin
      @(posedge clk); #1; w++;
    end
    chk("drain_pending", exp_sum_q.size(), 0);
  endtask

  task automatic quiet_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("no_out_after_reset", out_valid, 1'b0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  base;
    bit  done;
    int  sizes [7];
    bit  lasts [7];
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_op_strobe", op_strobe, 1'b0);
    chk("rst_op_bus", op_bus, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_count", out_count, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full frame 1..8 with exact issue and result timing.
    for (int i = 1; i <= 8; i++) send(14'(i), 1'b0);
    chk("full_strobe_c1", op_strobe, 1'b1);
    chk("full_valid_c1", out_valid, 1'b0);
    @(posedge clk); #1; chk("full_valid_c2", out_valid, 1'b0);
    chk("full_strobe_once", op_strobe, 1'b0);
    @(posedge clk); #1; chk("full_valid_c3", out_valid, 1'b0);
    @(posedge clk); #1; chk("full_valid_c4", out_valid, 1'b1);
    chk("full_sum_36", out_sum, 15'd36);
    drain();

    // Short frame closed by in_last.
    send(14'd100, 1'b0); send(14'd200, 1'b0); send(14'd300, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("short_sum_600", out_sum, 15'd600);
    chk("short_count_3", out_count, 4'd3);
    drain();

    // Overflow wrap.
    for (int i = 0; i < 8; i++) send(14'h3FFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_sum", out_sum, 15'h7FF8);
    drain();

    // Backpressure: only two frames may be outstanding.
    out_ready = 1'b0;
    base = strobe_cnt;
    fork
      begin
        for (int f = 0; f < 4; f++)
          for (int w = 0; w < 8; w++) send(14'd1, 1'b0);
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        chk("bp_strobes_2", strobe_cnt - base, 2);
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_no_strobe", op_strobe, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_strobes_4", strobe_cnt - base, 4);

    // Reset mid-frame and right after an issue.
    for (int i = 0; i < 5; i++) send(14'd7, 1'b0);
    do_reset();
    chk("mid_rst_in_ready", in_ready, 1'b1);
    quiet_check(6);
    for (int i = 0; i < 8; i++) send(14'd5, 1'b0);
    chk("pre_rst_strobe", op_strobe, 1'b1);
    @(posedge clk); #1;
    do_reset();
    quiet_check(6);
    for (int i = 0; i < 8; i++) send(14'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_sum_16", out_sum, 15'd16);
    drain();

    // Bursty input with random gaps and random output stalls.
    sizes = '{1, 8, 3, 8, 5, 1, 8};
    lasts = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 7; f++) begin
          for (int w = 0; w < sizes[f]; w++) begin
            send(14'($urandom_range(0, 16383)), (w == sizes[f] - 1) && lasts[f]);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("lanes_all_issued", exp_lane_q.size(), 0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_tree_feeder.md
# adder_tree_feeder

Stream-side front end for the 3-level adder tree. It gathers a valid/ready stream of ADDER_WIDTH-bit words into frames of 2^LEVELS operands and drives them in parallel onto the tree's operand inputs. It tracks the tree's fixed pipeline latency, captures each returned sum, and emits results on a valid/ready output stream, applying credit-based backpressure because the tree itself cannot stall.

## Interface
- ADDER_WIDTH, 14, operand width.
- LEVELS, 3, tree depth; N = 2^LEVELS operand lanes.
- TREE_LATENCY, 2, cycles from the operand-sampling edge to the sum being valid on tree_sum.
- RESULT_DEPTH, 2, result FIFO entries, which is also the maximum number of outstanding frames.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  feeder can accept a word.
- in_data  in  ADDER_WIDTH  operand word.
- in_last  in  1  closes the current frame early; qualified by in_valid.
- op_bus  out  N*ADDER_WIDTH  operand lanes to the tree; lane k = op_bus[k*ADDER_WIDTH +: ADDER_WIDTH]; lane 0 = first word of the frame.
- op_strobe  out  1  op_bus holds a new frame this cycle.
- tree_sum  in  ADDER_WIDTH+1  registered sum from the tree.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ADDER_WIDTH+1  frame sum.
- out_count  out  LEVELS+1  number of real words in the frame (1..N).

## Operation
- **Gather.** A word is accepted when in_valid && in_ready. It is written to lane wr_idx, and wr_idx increments.
  - The frame completes when the Nth word is accepted, or when any accepted word has in_last=1.
  - On completion, lanes not yet written are zero. cnt = wr_idx+1 is latched as the frame count.
  - in_last on the Nth word is identical to a plain full frame.
- **in_ready.** in_ready = !frame_full. While a complete frame waits to issue, no words are accepted.
- **Issue.** A frame issues when frame_full && credits > 0.
  - credits = RESULT_DEPTH − fifo_count − inflight.
  - In the issue cycle, op_strobe = 1 and op_bus holds the frame. op_bus stays unchanged until the next issue.
  - The next cycle, frame_full = 0, wr_idx = 0 and lanes are zeroed.
- **Track.** A TREE_LATENCY-deep shift register carries {strobe, count}. inflight = number of set strobe bits.
  - When the last stage is set, tree_sum and its count are pushed into the result FIFO in the same cycle.
- **Output.** out_valid = FIFO not empty; out_sum/out_count = FIFO head. The head pops on out_valid && out_ready.
  - Push and pop in the same cycle are both honoured.
  - The credit rule guarantees a push never finds the FIFO full.
- **Width.** The tree's output register is ADDER_WIDTH+1 bits, and the tree drops its upper carry bits. out_sum = (sum of lanes) mod 2^(ADDER_WIDTH+1). The feeder passes tree_sum through unmodified.
- **Reset.** Synchronous reset clears all state:
  - the partial frame is dropped;
  - wr_idx = 0, frame_full = 0, lanes = 0;
  - strobe pipeline cleared, so in-flight tree results arriving after reset are ignored;
  - FIFO emptied.

## Timing
- Values after reset: in_ready=1, op_strobe=0, op_bus=0, out_valid=0, out_sum=0, out_count=0.
- Issue is at the earliest one cycle after the completing word is accepted (frame_full is registered).
- If op_strobe is high in cycle t:
  - the tree samples op_bus at the end of t;
  - tree_sum is valid in cycle t+TREE_LATENCY;
  - it is pushed at the end of that cycle;
  - out_valid rises in t+TREE_LATENCY+1 (t+3 by default).
- Word-to-result latency for a full frame: last word accepted in cycle c → out_valid in c+4.
- Sustained throughput with out_ready=1 is N words per N+1 cycles: one bubble per frame while frame_full.
- Results leave in issue order. Nothing is reordered or dropped.

## Test plan
- **Full frame.** Words 1..8 back-to-back, out_ready=1 → op_strobe once with lanes 1..8; out_valid exactly 3 cycles later; out_sum=36, out_count=8.
- **Short frame.** Words 100, 200, 300 with in_last on 300 → lanes 3..7 = 0; out_sum=600, out_count=3.
- **Overflow wrap.** 8 words of 0x3FFF → true sum 0x1FFF8; out_sum=0x7FF8, out_count=8.
- **Backpressure.** out_ready=0 while streaming 4 full frames of all-ones:
  - frames 1 and 2 issue;
  - frame 3 completes, holds with in_ready=0 and no op_strobe;
  - then out_ready=1 → four results of 8 in order, and frame 4 accepted only after credits free.
- **Reset mid-frame.** Reset after 5 accepted words, and again 1 cycle after an op_strobe → no out_valid ever results from those; the next frame of eight 2s gives out_sum=16.
- **Bursty input.** Random in_valid gaps plus in_last at 1 and at 8 words → sums and counts match a reference model; op_bus is stable between strobes.
